// File: rtl/fir_sample_streamer.sv
// fir_sample_streamer: plays a host-loaded signed sample table onto the
// FIR filter input at a programmable sample period, optionally looping,
// then appends TAPS zero samples and pulses done.
module fir_sample_streamer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DIV_W  = 8,
  parameter int TAPS   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]          len,
  input  logic [DIV_W-1:0]         div,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     abort,
  output logic signed [DATA_W-1:0] x,
  output logic                     x_valid,
  output logic [ADDR_W-1:0]        idx,
  output logic                     busy,
  output logic                     done
);

  localparam int FL_W = $clog2(TAPS + 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [FL_W-1:0] TAPS_L  = FL_W'(TAPS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  logic signed [DATA_W-1:0] tbl_r [DEPTH];

  state_t                   state_r, state_s;
  logic [DIV_W-1:0]         cnt_r, cnt_s;
  logic [ADDR_W-1:0]        rd_r, rd_s;
  logic [ADDR_W-1:0]        last_r, last_s;
  logic [DIV_W-1:0]         div_r, div_s;
  logic                     loop_r, loop_s;
  logic [FL_W-1:0]          flush_r, flush_s;
  logic signed [DATA_W-1:0] x_r, x_s;
  logic                     x_valid_r, x_valid_s;
  logic [ADDR_W-1:0]        idx_r, idx_s;
  logic                     busy_r, busy_s;
  logic                     done_r, done_s;
  logic [ADDR_W:0]          len_eff_s;

  // Lengths beyond the table size are clamped to the full table.
  assign len_eff_s = (len > DEPTH_L) ? DEPTH_L : len;

  // Sample table: host writes are accepted only while idle (no reset on storage).
  always_ff @(posedge clk) begin
    if (wr_en && (state_r == IDLE)) begin
      tbl_r[wr_addr] <= wr_data;
    end
  end

  // Next-state and next-output logic; a strobe fires whenever the period counter is 0.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    rd_s      = rd_r;
    last_s    = last_r;
    div_s     = div_r;
    loop_s    = loop_r;
    flush_s   = flush_r;
    x_s       = x_r;
    x_valid_s = 1'b0;
    idx_s     = idx_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    if (abort) begin
      state_s = IDLE;
      cnt_s   = '0;
      rd_s    = '0;
      flush_s = '0;
      x_s     = '0;
      idx_s   = '0;
      busy_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            div_s  = div;
            loop_s = loop;
            cnt_s  = '0;
            rd_s   = '0;
            if (len_eff_s == '0) begin
              // Empty playback: reuse the flush exit path so done fires one clock later.
              state_s = FLUSH;
              flush_s = TAPS_L;
            end else begin
              state_s = RUN;
              last_s  = ADDR_W'(len_eff_s - (ADDR_W + 1)'(1));
              flush_s = '0;
            end
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          if (cnt_r == '0) begin
            x_s       = tbl_r[rd_r];
            idx_s     = rd_r;
            x_valid_s = 1'b1;
            busy_s    = 1'b1;
            cnt_s     = div_r;
            // Explicit compare against L-1 so a full-depth table wraps cleanly.
            if (rd_r == last_r) begin
              rd_s = '0;
              if (loop_r) begin
                state_s = RUN;
              end else begin
                state_s = FLUSH;
                flush_s = '0;
              end
            end else begin
              rd_s = rd_r + ADDR_W'(1);
            end
          end else begin
            cnt_s = cnt_r - DIV_W'(1);
          end
        end
        FLUSH: begin
          if (cnt_r == '0) begin
            if (flush_r == TAPS_L) begin
              state_s = IDLE;
              done_s  = 1'b1;
              busy_s  = 1'b0;
            end else begin
              x_s       = '0;
              idx_s     = '0;
              x_valid_s = 1'b1;
              busy_s    = 1'b1;
              flush_s   = flush_r + FL_W'(1);
              cnt_s     = div_r;
            end
          end else begin
            cnt_s = cnt_r - DIV_W'(1);
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
          rd_s    = '0;
          flush_s = '0;
          x_s     = '0;
          idx_s   = '0;
          busy_s  = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      rd_r      <= '0;
      last_r    <= '0;
      div_r     <= '0;
      loop_r    <= 1'b0;
      flush_r   <= '0;
      x_r       <= '0;
      x_valid_r <= 1'b0;
      idx_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      rd_r      <= rd_s;
      last_r    <= last_s;
      div_r     <= div_s;
      loop_r    <= loop_s;
      flush_r   <= flush_s;
      x_r       <= x_s;
      x_valid_r <= x_valid_s;
      idx_r     <= idx_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign x       = x_r;
  assign x_valid = x_valid_r;
  assign idx     = idx_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_fir_sample_streamer.sv
// Testbench for fir_sample_streamer: directed test-plan scenarios with literal
// expectations plus randomized playbacks checked every cycle against a
// closed-form model of the output schedule.
module tb_fir_sample_streamer;

  localparam int DEPTH = 16;
  localparam int TAPS  = 4;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [3:0]        wr_addr;
  logic signed [7:0] wr_data;
  logic [4:0]        len;
  logic [7:0]        div;
  logic              loop;
  logic              start;
  logic              abort;
  logic signed [7:0] x;
  logic              x_valid;
  logic [3:0]        idx;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;

  fir_sample_streamer dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .div(div), .loop(loop), .start(start), .abort(abort),
    .x(x), .x_valid(x_valid), .idx(idx), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [7:0] x;
    logic [3:0] idx;
    logic       xv;
    logic       busy;
    logic       done;
    logic       fin;
  } exp_t;

  exp_t       exp_r;
  logic [7:0] tbl_m [DEPTH];
  bit         mode_m;   // 0 = idle, 1 = playback requested/active
  int         t_m;      // edges since the start edge
  int         L_m;
  int         P_m;
  bit         lp_m;

  // Outputs at edge t after the start edge, from the sample schedule:
  // sample k strobes at t = 1 + k*P; done at t = 1 + (L+TAPS)*P.
  function automatic exp_t model_step(exp_t prev);
    exp_t e;
    int k;
    e = prev;
    e.xv = 1'b0;
    e.done = 1'b0;
    e.fin = 1'b0;
    if (L_m == 0) begin
      e.done = 1'b1;
      e.fin = 1'b1;
      return e;
    end
    k = (t_m - 1) / P_m;
    if (((t_m - 1) % P_m) == 0 && (lp_m || k < L_m + TAPS)) begin
      e.xv = 1'b1;
      e.busy = 1'b1;
      if (lp_m || k < L_m) begin
        e.x = tbl_m[k % L_m];
        e.idx = 4'(k % L_m);
      end else begin
        e.x = 8'd0;
        e.idx = 4'd0;
      end
    end else if (!lp_m && t_m == 1 + (L_m + TAPS) * P_m) begin
      e.done = 1'b1;
      e.busy = 1'b0;
      e.fin = 1'b1;
    end
    return e;
  endfunction

  // Model register: reacts to the same sampled inputs as the DUT.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_r  <= '0;
      mode_m <= 1'b0;
      t_m    <= 0;
    end else begin
      if (wr_en && !mode_m) tbl_m[wr_addr] <= wr_data;
      if (abort) begin
        exp_r  <= '0;
        mode_m <= 1'b0;
      end else if (!mode_m) begin
        exp_r.xv   <= 1'b0;
        exp_r.done <= 1'b0;
        if (start) begin
          mode_m <= 1'b1;
          t_m    <= 1;
          L_m    <= (int'(len) > DEPTH) ? DEPTH : int'(len);
          P_m    <= int'(div) + 1;
          lp_m   <= loop;
        end
      end else begin
        exp_r <= model_step(exp_r);
        if (model_step(exp_r).fin) mode_m <= 1'b0;
        t_m <= t_m + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (reset) begin
      chk("cmp_x", int'(x), int'($signed(exp_r.x)));
      chk("cmp_x_valid", int'(x_valid), int'(exp_r.xv));
      chk("cmp_idx", int'(idx), int'(exp_r.idx));
      chk("cmp_busy", int'(busy), int'(exp_r.busy));
      chk("cmp_done", int'(done), int'(exp_r.done));
      if (done && x_valid) chk("done_and_valid", 1, 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input int d);
    wr_en = 1'b1;
    wr_addr = 4'(a);
    wr_data = 8'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input int l, input int d, input bit lp);
    start = 1'b1;
    len = 5'(l);
    div = 8'(d);
    loop = lp;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (mode_m && n < budget) begin
      tick();
      n++;
    end
    chk("wait_idle_timeout", int'(mode_m), 0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int nv;
    reset = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    len = '0; div = '0; loop = 1'b0; start = 1'b0; abort = 1'b0;
    #22;
    chk("rst_x", int'(x), 0);
    chk("rst_x_valid", int'(x_valid), 0);
    chk("rst_idx", int'(idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) do_write(i, (i < 6) ? 5 * (i + 1) : -3 * i);

    // Basic playback.
    do_start(6, 0, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk("basic_x", int'(x), (c <= 6) ? 5 * c : 0);
      chk("basic_x_valid", int'(x_valid), (c <= 10) ? 1 : 0);
      chk("basic_busy", int'(busy), (c <= 10) ? 1 : 0);
      chk("basic_done", int'(done), (c == 11) ? 1 : 0);
      chk("basic_idx", int'(idx), (c <= 6) ? c - 1 : 0);
      if (c == 1) chk("model_first_x", int'($signed(exp_r.x)), 5);
      if (c == 11) chk("model_done", int'(exp_r.done), 1);
    end

    // Divided rate, P = 3.
    do_start(6, 2, 1'b0);
    for (int c = 1; c <= 32; c++) begin
      tick();
      chk("div_x_valid", int'(x_valid), (((c - 1) % 3) == 0 && c <= 28) ? 1 : 0);
      chk("div_done", int'(done), (c == 31) ? 1 : 0);
      if (c <= 18) chk("div_x", int'(x), 5 * ((c - 1) / 3 + 1));
      if (c == 28) chk("model_div_xv", int'(exp_r.xv), 1);
    end

    // Loop then abort.
    do_start(3, 0, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("loop_x", int'(x), 5 * ((c - 1) % 3 + 1));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_x", int'(x), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_x_valid", int'(x_valid), 0);
    tick();
    chk("abort_no_done", int'(done), 0);

    // Zero length.
    do_start(0, 0, 1'b0);
    tick();
    chk("len0_done", int'(done), 1);
    chk("len0_x_valid", int'(x_valid), 0);
    chk("len0_busy", int'(busy), 0);
    tick();
    chk("len0_done_clear", int'(done), 0);

    // Oversized length clamps to the table depth.
    do_start(20, 0, 1'b0);
    nv = 0;
    for (int c = 1; c <= 21; c++) begin
      tick();
      nv += int'(x_valid);
      if (c == 16) begin
        chk("len20_last_x", int'(x), -45);
        chk("len20_last_idx", int'(idx), 15);
      end
      if (c == 21) chk("len20_done", int'(done), 1);
    end
    chk("len20_strobes", nv, 20);
    tick();

    // Full depth with P = 2.
    do_start(16, 1, 1'b0);
    for (int c = 1; c <= 33; c++) begin
      tick();
      if (c == 31) chk("len16_idx15", int'(idx), 15);
      if (c == 33) begin
        chk("len16_flush_x", int'(x), 0);
        chk("len16_flush_idx", int'(idx), 0);
        chk("len16_flush_xv", int'(x_valid), 1);
      end
    end
    wait_idle(100);

    // Write and start while busy are ignored.
    do_start(6, 0, 1'b0);
    tick();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'd99;
    start = 1'b1; len = 5'd2;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("busy_ign_x", int'(x), 10);
    wait_idle(100);
    do_start(1, 0, 1'b0);
    tick();
    chk("old_tbl0", int'(x), 5);
    wait_idle(100);

    // Async reset mid-playback.
    do_start(6, 0, 1'b0);
    tick(); tick(); tick();
    chk("pre_rst_x", int'(x), 15);
    #2 reset = 1'b0;
    #1;
    chk("arst_x", int'(x), 0);
    chk("arst_x_valid", int'(x_valid), 0);
    chk("arst_idx", int'(idx), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    #3 reset = 1'b1;
    tick();
    do_start(6, 0, 1'b0);
    tick();
    chk("replay_x", int'(x), 5);
    chk("replay_idx", int'(idx), 0);
    wait_idle(100);

    // Randomized playbacks, checked by the per-cycle compare.
    for (int r = 0; r < 40; r++) begin
      if ($urandom % 2 == 0) begin
        for (int w = 0; w < 3; w++) do_write($urandom_range(0, 15), $urandom_range(0, 255));
      end
      do_start($urandom_range(0, 20), $urandom_range(0, 3), ($urandom % 4) == 0);
      if (loop || ($urandom % 5) == 0) begin
        for (int n = $urandom_range(1, 60); n > 0; n--) begin
          wr_en = (($urandom % 6) == 0);
          wr_addr = 4'($urandom_range(0, 15));
          wr_data = 8'($urandom_range(0, 255));
          start = (($urandom % 10) == 0);
          tick();
          wr_en = 1'b0;
          start = 1'b0;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      wait_idle(400);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
